mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit, one radix-2 step per clock
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             op_q, op_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dz_q, dz_d;

    logic             neg_a, neg_b, accept, b_zero, div_ge;
    logic [WIDTH-1:0] mag_a, mag_b, div_diff, step_acc, step_sh, quo_fix, rem_fix;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // Iterate on magnitudes; signs are reapplied combinationally on the final step.
    assign neg_a  = sgn & a[WIDTH-1];
    assign neg_b  = sgn & b[WIDTH-1];
    assign mag_a  = neg_a ? -a : a;
    assign mag_b  = neg_b ? -b : b;
    assign b_zero = (b == '0);
    assign accept = start && (state_q != S_RUN);

    // Multiply: shift-add with the multiplier shifting out of sh_q as product bits enter.
    assign mul_sum   = {1'b0, acc_q} + {1'b0, (sh_q[0] ? opb_q : '0)};
    // Divide: restoring, dividend bits leave sh_q MSB-first while quotient bits enter.
    assign div_shift = {acc_q, sh_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;

    always_comb begin
        step_acc = '0;
        step_sh  = '0;
        if (!op_q) begin
            step_acc = mul_sum[WIDTH:1];
            step_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end else begin
            step_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_sh  = {sh_q[WIDTH-2:0], div_ge};
        end
    end

    assign prod     = {step_acc, step_sh};
    assign prod_fix = neg_q_q ? -prod : prod;
    assign quo_fix  = neg_q_q ? -step_sh : step_sh;
    assign rem_fix  = neg_r_q ? -step_acc : step_acc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    op_d    = op;
                    neg_q_d = neg_a ^ neg_b;
                    neg_r_d = neg_a;
                    opb_d   = mag_b;
                    cnt_d   = '0;
                    acc_d   = '0;
                    sh_d    = mag_a;
                    dz_d    = op & b_zero;
                    state_d = (op && b_zero) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = step_acc;
                sh_d  = step_sh;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    hi_d    = op_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_d    = op_q ? quo_fix : prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            dz_q    <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - table, corner-sequence and random checks of mult_div_unit
module tb_mult_div_unit;
    logic        clk, reset, start, op, sgn;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: full-width arithmetic on sign/zero-extended operands.
    task automatic model(input logic mop, input logic msg, input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] eh, output logic [31:0] el, output logic edz);
        logic [63:0] xa, xb, p;
        longint sa, sb, q, r;
        edz = 1'b0;
        if (!mop) begin
            xa = msg ? {{32{ma[31]}}, ma} : {32'b0, ma};
            xb = msg ? {{32{mb[31]}}, mb} : {32'b0, mb};
            p  = xa * xb;
            eh = p[63:32];
            el = p[31:0];
        end else if (mb == 0) begin
            edz = 1'b1;
            eh  = prev_hi;
            el  = prev_lo;
        end else if (msg) begin
            sa = longint'($signed(ma));
            sb = longint'($signed(mb));
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end else begin
            eh = ma % mb;
            el = ma / mb;
        end
        if (!edz) begin
            prev_hi = eh;
            prev_lo = el;
        end
    endtask

    task automatic start_op(input logic sop, input logic ssg, input logic [31:0] sa, input logic [31:0] sb);
        start = 1'b1; op = sop; sgn = ssg; a = sa; b = sb;
        @(posedge clk); #1;
        start = 1'b0; op = $urandom_range(1, 0); sgn = $urandom_range(1, 0);
        a = $urandom(); b = $urandom();
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic rop, input logic rsg, input logic [31:0] ra, input logic [31:0] rb,
                          input int gap, output logic gbusy, output int lat);
        repeat (gap) @(negedge clk);
        start_op(rop, rsg, ra, rb);
        gbusy = busy;
        wait_done(lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    vec_t vt[15];
    logic [31:0] eh, el, sh, sl;
    logic        edz, gbusy;
    int          lat, dones;

    initial begin
        vt[0]  = '{0, 1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 0};
        vt[1]  = '{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0};
        vt[2]  = '{0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         0};
        vt[3]  = '{1, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
        vt[4]  = '{1, 0, 32'd100,       32'd7,        32'd2,         32'd14,        0};
        vt[5]  = '{1, 0, 32'h451,       32'h20,       32'h11,        32'h22,        0};
        vt[6]  = '{1, 0, 32'd123,       32'd0,        32'h11,        32'h22,        1};
        vt[7]  = '{1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0};
        vt[8]  = '{1, 1, 32'd5,         32'd0,        32'h0,         32'h8000_0000, 1};
        vt[9]  = '{0, 0, 32'h8000_0000, 32'd2,        32'h1,         32'h0,         0};
        vt[10] = '{0, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        0};
        vt[11] = '{1, 1, 32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 0};
        vt[12] = '{1, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3,         0};
        vt[13] = '{1, 0, 32'hFFFF_FFFF, 32'd1,        32'h0,         32'hFFFF_FFFF, 0};
        vt[14] = '{1, 0, 32'd5,         32'd7,        32'd5,         32'd0,         0};

        reset = 1'b0; start = 1'b0; op = 1'b0; sgn = 1'b0; a = '0; b = '0;
        #2;
        check("rst_hilo", {hi, lo}, 64'h0);
        check("rst_flags", {busy, done, div_zero}, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Entry 0 is issued in the same step as reset release.
        for (int i = 0; i < 15; i++) begin
            run_op(vt[i].op, vt[i].sgn, vt[i].a, vt[i].b, (i == 0) ? 0 : 1, gbusy, lat);
            model(vt[i].op, vt[i].sgn, vt[i].a, vt[i].b, eh, el, edz);
            check($sformatf("tbl%0d_lat", i), 64'(lat), vt[i].dz ? 64'd0 : 64'd32);
            check($sformatf("tbl%0d_busy", i), 64'(gbusy), vt[i].dz ? 64'd0 : 64'd1);
            check($sformatf("tbl%0d_hi", i), 64'(hi), 64'(vt[i].hi));
            check($sformatf("tbl%0d_lo", i), 64'(lo), 64'(vt[i].lo));
            check($sformatf("tbl%0d_dz", i), 64'(div_zero), 64'(vt[i].dz));
            sh = hi; sl = lo;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_pulse", i), 64'(done), 64'd0);
            check($sformatf("tbl%0d_hold", i), {hi, lo}, {sh, sl});
        end

        // A start while running (here a divide by zero) must be ignored.
        @(negedge clk);
        start_op(0, 0, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 1'b1; sgn = 1'b1; a = 32'd100; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        wait_done(lat);
        model(0, 0, 32'd3, 32'd4, eh, el, edz);
        check("ign_lat", 64'(lat), 64'd28);
        check("ign_res", {hi, lo, 31'b0, div_zero}, {eh, el, 32'h0});

        // Back-to-back: issue from the DONE cycle.
        start_op(1, 1, 32'hFFFF_FF9C, 32'd7);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_done_lo", 64'(done), 64'd0);
        wait_done(lat);
        model(1, 1, 32'hFFFF_FF9C, 32'd7, eh, el, edz);
        check("b2b_lat", 64'(lat), 64'd32);
        check("b2b_res", {hi, lo}, {eh, el});

        // Reset mid-run: async clear, then no stray done.
        @(negedge clk);
        start_op(0, 0, 32'h1234, 32'h5678);
        repeat (4) @(negedge clk);
        start = 1'b1; a = 32'h9; b = 32'h9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'h0);
        check("abort_flags", {busy, done, div_zero}, 3'b000);
        prev_hi = '0; prev_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_nodone", 64'(dones), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 150; i++) begin
            logic        rop, rsg;
            logic [31:0] ra, rb;
            rop = $urandom_range(1, 0);
            rsg = $urandom_range(1, 0);
            ra  = pick();
            rb  = pick();
            run_op(rop, rsg, ra, rb, $urandom_range(0, 2), gbusy, lat);
            model(rop, rsg, ra, rb, eh, el, edz);
            check($sformatf("rnd%0d_lat", i), 64'(lat), edz ? 64'd0 : 64'd32);
            check($sformatf("rnd%0d_busy", i), 64'(gbusy), edz ? 64'd0 : 64'd1);
            check($sformatf("rnd%0d_res op%0d s%0d a%0h b%0h", i, rop, rsg, ra, rb),
                  {hi, lo, 31'b0, div_zero}, {eh, el, 31'b0, edz});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
